emin_sched: RTL and testbench

- Row scheduler for the emin datapath. Walks the row index i from i_lo to i_hi and launches one emin row per i.
- Collects the streamed Emin(j,i) results, forwards each one to the E buffer write port, and reports the per-row minimum and its argmin j.
- Owns the T BRAM read-address mux. The emin block drives it while a sweep is active; an external requester is granted only when idle.

---
 rtl/emin_sched.sv | 247 ++++++++++++++++++++++++
 tb/tb_emin_sched.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emin_sched.sv
// Row scheduler for the emin datapath: launches one emin row per index, forwards
// results to the E buffer, tracks each row's minimum/argmin and muxes the T read port.
module emin_sched #(
    parameter int BIT_WIDTH = 32,
    parameter int I         = 160,
    parameter int TIMEOUT   = 1024,
    parameter int IW        = $clog2(I)
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        start_in,
    input  logic [IW-1:0]               i_lo_in,
    input  logic [IW-1:0]               i_hi_in,
    output logic                        busy_out,
    output logic                        done_out,
    output logic                        error_out,
    output logic [IW-1:0]               emin_i_out,
    output logic                        emin_valid_out,
    input  logic [IW-1:0]               emin_j_in,
    input  logic signed [BIT_WIDTH-1:0] emin_data_in,
    input  logic                        emin_valid_in,
    input  logic [IW-1:0]               emin_t_req_in,
    input  logic [IW-1:0]               ext_t_addr_in,
    output logic                        ext_grant_out,
    output logic [IW-1:0]               t_addr_out,
    output logic                        wr_en_out,
    output logic [IW-1:0]               wr_i_out,
    output logic [IW-1:0]               wr_j_out,
    output logic signed [BIT_WIDTH-1:0] wr_data_out,
    output logic                        min_valid_out,
    output logic [IW-1:0]               min_i_out,
    output logic [IW-1:0]               min_j_out,
    output logic signed [BIT_WIDTH-1:0] min_data_out
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [IW:0]                   I_LIM    = (IW + 1)'(I);
    localparam logic [WDW-1:0]                WD_LIMIT = WDW'(TIMEOUT);
    localparam logic [WDW-1:0]                WD_ONE   = {{(WDW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]                 IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};
    localparam logic signed [BIT_WIDTH-1:0]   MAX_POS  = {1'b0, {(BIT_WIDTH-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LAUNCH   = 3'd1,
        S_WAIT_ROW = 3'd2,
        S_ROW_END  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                      r_state;
    state_t                      w_next_state;
    logic [IW-1:0]               r_cur_i;
    logic [IW-1:0]               r_i_hi;
    logic [IW-1:0]               r_exp_j;
    logic [IW-1:0]               r_arg_j;
    logic [IW-1:0]               w_new_arg;
    logic signed [BIT_WIDTH-1:0] r_row_min;
    logic signed [BIT_WIDTH-1:0] w_new_min;
    logic [WDW-1:0]              r_wd;
    logic [WDW-1:0]              w_wd_inc;
    logic                        w_cfg_bad;
    logic                        w_accept;
    logic                        w_err_set;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_error;
    logic                        r_emin_valid;
    logic                        r_wr_en;
    logic                        r_min_valid;
    logic [IW-1:0]               r_wr_i;
    logic [IW-1:0]               r_wr_j;
    logic signed [BIT_WIDTH-1:0] r_wr_data;
    logic [IW-1:0]               r_min_i;
    logic [IW-1:0]               r_min_j;
    logic signed [BIT_WIDTH-1:0] r_min_data;

    assign w_cfg_bad = (i_hi_in < i_lo_in) || ({1'b0, i_hi_in} >= I_LIM);
    assign w_accept  = (r_state == S_WAIT_ROW) && emin_valid_in && (emin_j_in == r_exp_j);
    assign w_wd_inc  = r_wd + WD_ONE;

    // Running minimum including the current sample; strict compare keeps the earliest (smallest) j on ties.
    always_comb begin
        w_new_min = r_row_min;
        w_new_arg = r_arg_j;
        if (emin_data_in < r_row_min) begin
            w_new_min = emin_data_in;
            w_new_arg = emin_j_in;
        end else begin
            w_new_min = r_row_min;
            w_new_arg = r_arg_j;
        end
    end

    // Next-state logic and error detection.
    always_comb begin
        w_next_state = r_state;
        w_err_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_in && !w_cfg_bad) begin
                    w_next_state = S_LAUNCH;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LAUNCH: begin
                w_next_state = S_WAIT_ROW;
            end
            S_WAIT_ROW: begin
                if (emin_valid_in) begin
                    if (emin_j_in != r_exp_j) begin
                        w_next_state = S_IDLE;
                        w_err_set    = 1'b1;
                    end else if (emin_j_in == r_cur_i) begin
                        w_next_state = S_ROW_END;
                    end else begin
                        w_next_state = S_WAIT_ROW;
                    end
                end else if (w_wd_inc == WD_LIMIT) begin
                    w_next_state = S_IDLE;
                    w_err_set    = 1'b1;
                end else begin
                    w_next_state = S_WAIT_ROW;
                end
            end
            S_ROW_END: begin
                if (r_cur_i == r_i_hi) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_LAUNCH;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // T port ownership follows the state directly so the external requester sees it without delay.
    always_comb begin
        ext_grant_out = 1'b0;
        t_addr_out    = emin_t_req_in;
        if (r_state == S_IDLE) begin
            ext_grant_out = 1'b1;
            t_addr_out    = ext_t_addr_in;
        end else begin
            ext_grant_out = 1'b0;
            t_addr_out    = emin_t_req_in;
        end
    end

    // State register, control strobes, sticky error and row index.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_emin_valid <= 1'b0;
            r_wr_en      <= 1'b0;
            r_min_valid  <= 1'b0;
            r_cur_i      <= '0;
            r_i_hi       <= '0;
        end else begin
            r_state      <= w_next_state;
            r_busy       <= (w_next_state != S_IDLE);
            r_done       <= (w_next_state == S_DONE);
            r_emin_valid <= (w_next_state == S_LAUNCH);
            r_wr_en      <= w_accept;
            r_min_valid  <= (w_next_state == S_ROW_END);
            if ((r_state == S_IDLE) && start_in) begin
                r_error <= w_cfg_bad;
                r_i_hi  <= i_hi_in;
                if (!w_cfg_bad) begin
                    r_cur_i <= i_lo_in;
                end
            end else if (w_err_set) begin
                r_error <= 1'b1;
            end
            if ((r_state == S_ROW_END) && (r_cur_i != r_i_hi)) begin
                r_cur_i <= r_cur_i + IDX_ONE;
            end
        end
    end

    // Per-row tracking: expected j, running minimum and the inter-event watchdog.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_exp_j   <= '0;
            r_row_min <= '0;
            r_arg_j   <= '0;
            r_wd      <= '0;
        end else if (r_state == S_LAUNCH) begin
            r_exp_j   <= '0;
            r_row_min <= MAX_POS;
            r_arg_j   <= '0;
            r_wd      <= WD_ONE;
        end else if (w_accept) begin
            r_exp_j   <= r_exp_j + IDX_ONE;
            r_row_min <= w_new_min;
            r_arg_j   <= w_new_arg;
            r_wd      <= WD_ONE;
        end else if (r_state == S_WAIT_ROW) begin
            r_wd      <= w_wd_inc;
        end
    end

    // Write-port and row-minimum data registers; they hold between strobes.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_i     <= '0;
            r_wr_j     <= '0;
            r_wr_data  <= '0;
            r_min_i    <= '0;
            r_min_j    <= '0;
            r_min_data <= '0;
        end else if (w_accept) begin
            r_wr_i    <= r_cur_i;
            r_wr_j    <= emin_j_in;
            r_wr_data <= emin_data_in;
            if (emin_j_in == r_cur_i) begin
                r_min_i    <= r_cur_i;
                r_min_j    <= w_new_arg;
                r_min_data <= w_new_min;
            end
        end
    end

    assign busy_out       = r_busy;
    assign done_out       = r_done;
    assign error_out      = r_error;
    assign emin_i_out     = r_cur_i;
    assign emin_valid_out = r_emin_valid;
    assign wr_en_out      = r_wr_en;
    assign wr_i_out       = r_wr_i;
    assign wr_j_out       = r_wr_j;
    assign wr_data_out    = r_wr_data;
    assign min_valid_out  = r_min_valid;
    assign min_i_out      = r_min_i;
    assign min_j_out      = r_min_j;
    assign min_data_out   = r_min_data;

endmodule

// File: tb/tb_emin_sched.sv
// Bench for emin_sched: a behavioural emin drives result streams and a scoreboard
// checks every E-buffer write and row-minimum report.
module tb_emin_sched;

    localparam int BW  = 32;
    localparam int NI  = 160;
    localparam int TO  = 1024;
    localparam int IW  = 8;
    localparam int LAT = 2;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic                 start_in;
    logic [IW-1:0]        i_lo_in, i_hi_in;
    logic                 busy_out, done_out, error_out;
    logic [IW-1:0]        emin_i_out;
    logic                 emin_valid_out;
    logic [IW-1:0]        emin_j_in;
    logic signed [BW-1:0] emin_data_in;
    logic                 emin_valid_in;
    logic [IW-1:0]        emin_t_req_in, ext_t_addr_in;
    logic                 ext_grant_out;
    logic [IW-1:0]        t_addr_out;
    logic                 wr_en_out;
    logic [IW-1:0]        wr_i_out, wr_j_out;
    logic signed [BW-1:0] wr_data_out;
    logic                 min_valid_out;
    logic [IW-1:0]        min_i_out, min_j_out;
    logic signed [BW-1:0] min_data_out;

    emin_sched #(.BIT_WIDTH(BW), .I(NI), .TIMEOUT(TO)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .i_lo_in(i_lo_in), .i_hi_in(i_hi_in),
        .busy_out(busy_out), .done_out(done_out), .error_out(error_out),
        .emin_i_out(emin_i_out), .emin_valid_out(emin_valid_out),
        .emin_j_in(emin_j_in), .emin_data_in(emin_data_in), .emin_valid_in(emin_valid_in),
        .emin_t_req_in(emin_t_req_in), .ext_t_addr_in(ext_t_addr_in),
        .ext_grant_out(ext_grant_out), .t_addr_out(t_addr_out),
        .wr_en_out(wr_en_out), .wr_i_out(wr_i_out), .wr_j_out(wr_j_out), .wr_data_out(wr_data_out),
        .min_valid_out(min_valid_out), .min_i_out(min_i_out), .min_j_out(min_j_out),
        .min_data_out(min_data_out)
    );

    always #5 clk_in = ~clk_in;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int n_wr = 0, n_min = 0, n_done = 0, n_launch = 0;
    int model_mode = 0;  // 0: data=10-j, 1: tie table, 2: j sequence 0,2, 3: silent

    logic [IW-1:0]        q_wi[$], q_wj[$], q_mi[$], q_mj[$];
    logic signed [BW-1:0] q_wd[$], q_md[$];

    logic [IW-1:0]        m_i, m_j;
    logic signed [BW-1:0] m_d;

    always @(posedge clk_in) cyc++;

    function automatic logic signed [BW-1:0] model_data(input int mode, input int j);
        logic signed [BW-1:0] d;
        if (mode == 1) begin
            case (j)
                0:       d = -32'sd5;
                1:       d = 32'sd7;
                2:       d = -32'sd5;
                3:       d = 32'sd2;
                default: d = 32'sd0;
            endcase
        end else begin
            d = 32'sd10 - j;
        end
        return d;
    endfunction

    // Behavioural emin: after a launch, stream j=0..i with fixed latency
    always begin
        @(negedge clk_in);
        if (!rst_in && emin_valid_out && model_mode != 3) begin
            m_i = emin_i_out;
            repeat (LAT) @(negedge clk_in);
            for (int j = 0; j <= int'(m_i); j++) begin
                if (rst_in) break;
                m_j = IW'(j);
                if (model_mode == 2 && j == 1) m_j = 8'd2;
                m_d = model_data(model_mode, int'(m_j));
                emin_valid_in = 1'b1;
                emin_j_in     = m_j;
                emin_data_in  = m_d;
                if (!(model_mode == 2 && m_j == 8'd2)) begin
                    q_wi.push_back(m_i);
                    q_wj.push_back(m_j);
                    q_wd.push_back(m_d);
                end
                @(negedge clk_in);
                if (model_mode == 2 && m_j == 8'd2) break;
            end
            emin_valid_in = 1'b0;
        end
    end

    // Scoreboard monitor
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (emin_valid_out) n_launch++;
            if (done_out) n_done++;
            if (wr_en_out) begin
                n_wr++;
                n_total++;
                if (q_wi.size() == 0) begin
                    $display("FAIL wr_unexpected got i=%0d j=%0d d=%0d, expected no write", wr_i_out, wr_j_out, wr_data_out);
                end else begin
                    logic [IW-1:0] ei, ej;
                    logic signed [BW-1:0] ed;
                    ei = q_wi.pop_front(); ej = q_wj.pop_front(); ed = q_wd.pop_front();
                    if (wr_i_out !== ei || wr_j_out !== ej || wr_data_out !== ed)
                        $display("FAIL wr_data got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", wr_i_out, wr_j_out, wr_data_out, ei, ej, ed);
                    else n_pass++;
                end
            end
            if (min_valid_out) begin
                n_min++;
                n_total++;
                if (q_mi.size() == 0) begin
                    $display("FAIL min_unexpected got (%0d,%0d,%0d), expected none", min_i_out, min_j_out, min_data_out);
                end else begin
                    logic [IW-1:0] ei, ej;
                    logic signed [BW-1:0] ed;
                    ei = q_mi.pop_front(); ej = q_mj.pop_front(); ed = q_md.pop_front();
                    if (min_i_out !== ei || min_j_out !== ej || min_data_out !== ed || wr_en_out !== 1'b1)
                        $display("FAIL min_report got (%0d,%0d,%0d) wr_en=%0b expected (%0d,%0d,%0d) wr_en=1",
                                 min_i_out, min_j_out, min_data_out, wr_en_out, ei, ej, ed);
                    else n_pass++;
                end
            end
        end
    end

    task automatic push_min(input logic [IW-1:0] i, input logic [IW-1:0] j, input logic signed [BW-1:0] d);
        q_mi.push_back(i); q_mj.push_back(j); q_md.push_back(d);
    endtask

    task automatic start_sweep(input logic [IW-1:0] lo, input logic [IW-1:0] hi);
        @(negedge clk_in);
        i_lo_in = lo; i_hi_in = hi; start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int seen);
        seen = 0;
        for (int k = 0; k < budget && seen == 0; k++) begin
            if (done_out) seen = 1;
            else @(negedge clk_in);
        end
    endtask

    task automatic test_reset;
        rst_in = 1'b1; start_in = 1'b0; i_lo_in = '0; i_hi_in = '0;
        emin_valid_in = 1'b0; emin_j_in = '0; emin_data_in = '0;
        emin_t_req_in = 8'h11; ext_t_addr_in = 8'h33;
        repeat (3) @(negedge clk_in);
        n_total++;
        if ({busy_out, done_out, error_out, emin_valid_out, wr_en_out, min_valid_out} !== 6'b0)
            $display("FAIL reset_strobes got %b expected 000000",
                     {busy_out, done_out, error_out, emin_valid_out, wr_en_out, min_valid_out});
        else n_pass++;
        n_total++;
        if (ext_grant_out !== 1'b1 || t_addr_out !== 8'h33)
            $display("FAIL reset_tport got grant=%0b addr=%0h expected grant=1 addr=33", ext_grant_out, t_addr_out);
        else n_pass++;
        rst_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_t_port;
        int seen, any_busy;
        ext_t_addr_in = 8'd7;
        @(negedge clk_in);
        n_total++;
        if (ext_grant_out !== 1'b1 || t_addr_out !== 8'd7)
            $display("FAIL tport_idle got grant=%0b addr=%0d expected grant=1 addr=7", ext_grant_out, t_addr_out);
        else n_pass++;
        model_mode = 0;
        push_min(8'd1, 8'd1, 32'sd9);
        start_sweep(8'd1, 8'd1);
        emin_t_req_in = 8'h2A;
        #1;
        n_total++;
        if (ext_grant_out !== 1'b0 || t_addr_out !== 8'h2A)
            $display("FAIL tport_busy got grant=%0b addr=%0h expected grant=0 addr=2a", ext_grant_out, t_addr_out);
        else n_pass++;
        wait_done(100, seen);
        @(negedge clk_in);
        n_total++;
        if (seen != 1 || ext_grant_out !== 1'b1 || t_addr_out !== 8'd7)
            $display("FAIL tport_return got done=%0d grant=%0b addr=%0d expected done=1 grant=1 addr=7", seen, ext_grant_out, t_addr_out);
        else n_pass++;
        // Inverted range, then an out-of-range upper bound
        any_busy = 0;
        start_sweep(8'd5, 8'd3);
        for (int k = 0; k < 5; k++) begin
            if (busy_out) any_busy = 1;
            @(negedge clk_in);
        end
        n_total++;
        if (error_out !== 1'b1 || any_busy != 0)
            $display("FAIL cfg_inverted got error=%0b busy_seen=%0d expected error=1 busy_seen=0", error_out, any_busy);
        else n_pass++;
        any_busy = 0;
        start_sweep(8'd0, 8'd200);
        for (int k = 0; k < 5; k++) begin
            if (busy_out) any_busy = 1;
            @(negedge clk_in);
        end
        n_total++;
        if (error_out !== 1'b1 || any_busy != 0)
            $display("FAIL cfg_range got error=%0b busy_seen=%0d expected error=1 busy_seen=0", error_out, any_busy);
        else n_pass++;
    endtask

    task automatic test_sweep;
        int seen, b_wr, b_min, b_done, b_launch;
        b_wr = n_wr; b_min = n_min; b_done = n_done; b_launch = n_launch;
        model_mode = 0;
        push_min(8'd0, 8'd0, 32'sd10);
        push_min(8'd1, 8'd1, 32'sd9);
        push_min(8'd2, 8'd2, 32'sd8);
        start_sweep(8'd0, 8'd2);
        n_total++;
        if (busy_out !== 1'b1 || error_out !== 1'b0)
            $display("FAIL sweep_start got busy=%0b error=%0b expected busy=1 error=0", busy_out, error_out);
        else n_pass++;
        wait_done(300, seen);
        @(negedge clk_in);
        n_total++;
        if (seen != 1 || busy_out !== 1'b0)
            $display("FAIL sweep_done got done=%0d busy=%0b expected done=1 busy=0", seen, busy_out);
        else n_pass++;
        repeat (5) @(negedge clk_in);
        n_total++;
        if (n_launch - b_launch != 3 || n_wr - b_wr != 6 || n_min - b_min != 3 || n_done - b_done != 1)
            $display("FAIL sweep_counts got launch=%0d wr=%0d min=%0d done=%0d expected 3 6 3 1",
                     n_launch - b_launch, n_wr - b_wr, n_min - b_min, n_done - b_done);
        else n_pass++;
    endtask

    task automatic test_tie;
        int seen, b_wr;
        b_wr = n_wr;
        model_mode = 1;
        push_min(8'd3, 8'd0, -32'sd5);
        start_sweep(8'd3, 8'd3);
        wait_done(100, seen);
        repeat (2) @(negedge clk_in);
        n_total++;
        if (seen != 1 || n_wr - b_wr != 4 || q_mi.size() != 0)
            $display("FAIL tie_row got done=%0d wr=%0d pending_min=%0d expected 1 4 0", seen, n_wr - b_wr, q_mi.size());
        else n_pass++;
    endtask

    task automatic test_bad_j;
        int b_wr, b_min, b_done, hit;
        b_wr = n_wr; b_min = n_min; b_done = n_done; hit = 0;
        model_mode = 2;
        start_sweep(8'd2, 8'd2);
        for (int k = 0; k < 50 && hit == 0; k++) begin
            if (error_out) hit = 1;
            else @(negedge clk_in);
        end
        repeat (3) @(negedge clk_in);
        n_total++;
        if (hit != 1 || busy_out !== 1'b0 || ext_grant_out !== 1'b1)
            $display("FAIL bad_j_abort got error_seen=%0d busy=%0b grant=%0b expected 1 0 1", hit, busy_out, ext_grant_out);
        else n_pass++;
        n_total++;
        if (n_wr - b_wr != 1 || n_min - b_min != 0 || n_done - b_done != 0)
            $display("FAIL bad_j_counts got wr=%0d min=%0d done=%0d expected 1 0 0", n_wr - b_wr, n_min - b_min, n_done - b_done);
        else n_pass++;
    endtask

    task automatic test_timeout;
        int t_launch, t_err, hit, seen;
        model_mode = 3;
        start_sweep(8'd0, 8'd0);
        t_launch = cyc;
        n_total++;
        if (error_out !== 1'b0 || emin_valid_out !== 1'b1)
            $display("FAIL start_clears_error got error=%0b launch=%0b expected error=0 launch=1", error_out, emin_valid_out);
        else n_pass++;
        hit = 0; t_err = 0;
        for (int k = 0; k < TO + 50 && hit == 0; k++) begin
            @(negedge clk_in);
            if (error_out) begin hit = 1; t_err = cyc; end
        end
        n_total++;
        if (hit != 1 || t_err - t_launch != TO)
            $display("FAIL timeout_delay got seen=%0d delay=%0d expected seen=1 delay=%0d", hit, t_err - t_launch, TO);
        else n_pass++;
        model_mode = 0;
        push_min(8'd0, 8'd0, 32'sd10);
        start_sweep(8'd0, 8'd0);
        n_total++;
        if (error_out !== 1'b0 || busy_out !== 1'b1)
            $display("FAIL restart_after_timeout got error=%0b busy=%0b expected error=0 busy=1", error_out, busy_out);
        else n_pass++;
        wait_done(100, seen);
        n_total++;
        if (seen != 1)
            $display("FAIL restart_done got %0d expected 1", seen);
        else n_pass++;
        @(negedge clk_in);
    endtask

    task automatic test_reset_mid;
        int b_wr;
        b_wr = n_wr;
        model_mode = 0;
        ext_t_addr_in = 8'h55;
        push_min(8'd0, 8'd0, 32'sd10);
        push_min(8'd1, 8'd1, 32'sd9);
        push_min(8'd2, 8'd2, 32'sd8);
        start_sweep(8'd0, 8'd2);
        for (int k = 0; k < 100 && n_wr < b_wr + 2; k++) @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        n_total++;
        if ({busy_out, done_out, error_out, emin_valid_out, wr_en_out, min_valid_out} !== 6'b0 ||
            emin_i_out !== 8'd0 || wr_i_out !== 8'd0 || wr_j_out !== 8'd0 || wr_data_out !== 32'sd0)
            $display("FAIL reset_mid_outputs got strobes=%b emin_i=%0d wr=(%0d,%0d,%0d) expected all 0",
                     {busy_out, done_out, error_out, emin_valid_out, wr_en_out, min_valid_out},
                     emin_i_out, wr_i_out, wr_j_out, wr_data_out);
        else n_pass++;
        n_total++;
        if (min_i_out !== 8'd0 || min_j_out !== 8'd0 || min_data_out !== 32'sd0 ||
            ext_grant_out !== 1'b1 || t_addr_out !== 8'h55)
            $display("FAIL reset_mid_min_tport got min=(%0d,%0d,%0d) grant=%0b addr=%0h expected (0,0,0) 1 55",
                     min_i_out, min_j_out, min_data_out, ext_grant_out, t_addr_out);
        else n_pass++;
        repeat (10) @(negedge clk_in);
        q_wi.delete(); q_wj.delete(); q_wd.delete();
        q_mi.delete(); q_mj.delete(); q_md.delete();
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        n_total++;
        if (busy_out !== 1'b0 || ext_grant_out !== 1'b1 || wr_en_out !== 1'b0)
            $display("FAIL reset_mid_idle got busy=%0b grant=%0b wr_en=%0b expected 0 1 0", busy_out, ext_grant_out, wr_en_out);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_t_port();
        test_sweep();
        test_tie();
        test_bad_j();
        test_timeout();
        test_reset_mid();
        n_total++;
        if (q_wi.size() != 0 || q_mi.size() != 0)
            $display("FAIL scoreboard_drain got wr=%0d min=%0d pending expected 0 0", q_wi.size(), q_mi.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
